// File: rtl/ledger_pkg.sv
// ledger_pkg
// Shared types and constants for the balance ledger.
//   txn_op_t  : request opcode carried on txn_op
//   status_t  : per-transaction result carried on resp_status
//   state_t   : control FSM state encoding
//   DISPLAY_MAX : largest value the 8-digit LED display can show
package ledger_pkg;

    typedef enum logic [1:0] {
        DEPOSIT  = 2'd0,
        WITHDRAW = 2'd1,
        CLEAR    = 2'd2,
        RSVD     = 2'd3
    } txn_op_t;

    typedef enum logic [1:0] {
        OK           = 2'd0,
        OVERFLOW     = 2'd1,
        INSUFFICIENT = 2'd2,
        BAD_OP       = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DISPLAY_MAX = 32'd99_999_999;

endpackage

// File: rtl/ledger_alu.sv
// ledger_alu
// Combinational evaluation of one ledger transaction against the current
// balance. Produces the candidate next balance and the status; the caller
// commits next_balance only when status is OK.
// Ports:
//   op           in  : transaction opcode
//   amount       in  : 32-bit amount (ignored by CLEAR / RSVD)
//   balance      in  : current committed balance
//   next_balance out : balance after the operation (equals balance on error)
//   status       out : OK / OVERFLOW / INSUFFICIENT / BAD_OP
module ledger_alu
    import ledger_pkg::*;
#(
    parameter logic [31:0] MAX_BALANCE = DISPLAY_MAX
) (
    input  txn_op_t     op,
    input  logic [31:0] amount,
    input  logic [31:0] balance,
    output logic [31:0] next_balance,
    output status_t     status
);

    // 33-bit arithmetic so a huge deposit cannot wrap past the limit check.
    logic [32:0] sum_w;
    logic [32:0] diff_w;

    assign sum_w  = {1'b0, balance} + {1'b0, amount};
    assign diff_w = {1'b0, balance} - {1'b0, amount};

    always_comb begin
        next_balance = balance;
        status       = OK;
        case (op)
            DEPOSIT: begin
                if (sum_w > {1'b0, MAX_BALANCE}) begin
                    status = OVERFLOW;
                end else begin
                    next_balance = sum_w[31:0];
                end
            end
            WITHDRAW: begin
                if ({1'b0, amount} > {1'b0, balance}) begin
                    status = INSUFFICIENT;
                end else begin
                    next_balance = diff_w[31:0];
                end
            end
            CLEAR: begin
                next_balance = 32'd0;
            end
            default: begin
                status = BAD_OP;
            end
        endcase
    end

endmodule

// File: rtl/balance_ledger.sv
// balance_ledger
// Holds the balance shown on the LED display. Accepts DEPOSIT / WITHDRAW /
// CLEAR requests over a valid/ready handshake, evaluates them in one cycle,
// commits only successful results, and returns a status over a second
// handshake. One transaction per three cycles at best (IDLE -> EXEC -> RESP).
// Ports:
//   clk         in  : system clock
//   rst_neg     in  : asynchronous active-low reset
//   txn_valid   in  : request present
//   txn_ready   out : request can be accepted (state IDLE)
//   txn_op      in  : 0 DEPOSIT, 1 WITHDRAW, 2 CLEAR, 3 reserved
//   txn_amount  in  : amount in minimum units
//   resp_valid  out : status present (state RESP)
//   resp_ready  in  : consumer takes the status
//   resp_status out : 0 OK, 1 OVERFLOW, 2 INSUFFICIENT, 3 BAD_OP
//   balance     out : committed balance, registered, never above MAX_BALANCE
//   txn_count   out : number of OK commits, wraps modulo 2^CNT_W
module balance_ledger
    import ledger_pkg::*;
#(
    parameter logic [31:0] MAX_BALANCE = DISPLAY_MAX,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_neg,
    input  logic             txn_valid,
    output logic             txn_ready,
    input  logic [1:0]       txn_op,
    input  logic [31:0]      txn_amount,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_status,
    output logic [31:0]      balance,
    output logic [CNT_W-1:0] txn_count
);

    state_t            state_q,   state_d;
    txn_op_t           op_q,      op_d;
    logic [31:0]       amount_q,  amount_d;
    logic [31:0]       balance_q, balance_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    status_t           status_q,  status_d;

    logic [31:0]       alu_balance;
    status_t           alu_status;

    ledger_alu #(
        .MAX_BALANCE (MAX_BALANCE)
    ) u_alu (
        .op           (op_q),
        .amount       (amount_q),
        .balance      (balance_q),
        .next_balance (alu_balance),
        .status       (alu_status)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (txn_valid)  state_d = EXEC;
            EXEC:                    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (state register only) ----------------
    always_comb begin
        txn_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        op_d      = op_q;
        amount_d  = amount_q;
        balance_d = balance_q;
        count_d   = count_q;
        status_d  = status_q;
        if (state_q == IDLE && txn_valid) begin
            op_d     = txn_op_t'(txn_op);
            amount_d = txn_amount;
        end
        if (state_q == EXEC) begin
            status_d = alu_status;
            if (alu_status == OK) begin
                balance_d = alu_balance;
                count_d   = count_q + 1'b1;
            end
        end
    end

    // ---------------- Datapath registers ----------------
    // Everything visible is a flop, so balance only moves on a commit edge.
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            op_q      <= DEPOSIT;
            amount_q  <= 32'd0;
            balance_q <= 32'd0;
            count_q   <= '0;
            status_q  <= OK;
        end else begin
            op_q      <= op_d;
            amount_q  <= amount_d;
            balance_q <= balance_d;
            count_q   <= count_d;
            status_q  <= status_d;
        end
    end

    assign balance     = balance_q;
    assign txn_count   = count_q;
    assign resp_status = status_q;

endmodule

// File: tb/tb_balance_ledger.sv
// Directed testbench for balance_ledger. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled there too, away from the edge.
module tb_balance_ledger;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_neg;
    logic             txn_valid;
    logic             txn_ready;
    logic [1:0]       txn_op;
    logic [31:0]      txn_amount;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_status;
    logic [31:0]      balance;
    logic [CNT_W-1:0] txn_count;

    int checks = 0;
    int errors = 0;

    balance_ledger #(
        .MAX_BALANCE (32'd99_999_999),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_neg     (rst_neg),
        .txn_valid   (txn_valid),
        .txn_ready   (txn_ready),
        .txn_op      (txn_op),
        .txn_amount  (txn_amount),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .balance     (balance),
        .txn_count   (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for txn_ready, present the request, and let it be accepted.
    task automatic send(input string tag, input logic [1:0] op, input logic [31:0] amt);
        int n = 0;
        while (!txn_ready && n < 50) begin
            tick();
            n++;
        end
        if (!txn_ready) check({tag, "_ready_timeout"}, {31'd0, txn_ready}, 32'd1);
        txn_valid  = 1'b1;
        txn_op     = op;
        txn_amount = amt;
        tick();                       // edge N: accepted
        txn_valid  = 1'b0;
        check({tag, "_exec_ready"}, {31'd0, txn_ready}, 32'd0);
        check({tag, "_exec_rvalid"}, {31'd0, resp_valid}, 32'd0);
    endtask

    // Complete a request that is in EXEC: check commit at N+1, then take the response.
    task automatic finish(input string tag, input logic [1:0] st, input logic [31:0] bal,
                          input int cnt);
        tick();                       // edge N+1: commit
        check({tag, "_rvalid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_status"}, {30'd0, resp_status}, {30'd0, st});
        check({tag, "_balance"}, balance, bal);
        check({tag, "_count"}, {16'd0, txn_count}, cnt[31:0]);
        resp_ready = 1'b1;
        tick();                       // edge M: response taken
        resp_ready = 1'b0;
        check({tag, "_ready_back"}, {31'd0, txn_ready}, 32'd1);
        check({tag, "_rvalid_drop"}, {31'd0, resp_valid}, 32'd0);
        $display("txn %s: status=%0d balance=%0d count=%0d", tag, resp_status, balance, txn_count);
    endtask

    task automatic do_txn(input string tag, input logic [1:0] op, input logic [31:0] amt,
                          input logic [1:0] st, input logic [31:0] bal, input int cnt);
        send(tag, op, amt);
        finish(tag, st, bal, cnt);
    endtask

    initial begin
        rst_neg    = 1'b0;
        txn_valid  = 1'b0;
        txn_op     = 2'd0;
        txn_amount = 32'd0;
        resp_ready = 1'b0;
        tick();
        tick();
        rst_neg = 1'b1;
        tick();

        // Reset state
        check("rst_ready",  {31'd0, txn_ready},   32'd1);
        check("rst_rvalid", {31'd0, resp_valid},  32'd0);
        check("rst_status", {30'd0, resp_status}, 32'd0);
        check("rst_balance", balance, 32'd0);
        check("rst_count",  {16'd0, txn_count},   32'd0);

        // Test 1 and 2: deposit, insufficient, exact withdraw
        do_txn("dep1234",   2'd0, 32'd1234, 2'd0, 32'd1234, 1);
        do_txn("wd1235",    2'd1, 32'd1235, 2'd2, 32'd1234, 1);
        do_txn("wd1234",    2'd1, 32'd1234, 2'd0, 32'd0,    2);

        // Test 3: limit and overflow without 32-bit wrap
        do_txn("dep_big",   2'd0, 32'd99_999_000, 2'd0, 32'd99_999_000, 3);
        do_txn("dep999",    2'd0, 32'd999,        2'd0, 32'd99_999_999, 4);
        do_txn("dep1_ovf",  2'd0, 32'd1,          2'd1, 32'd99_999_999, 4);
        do_txn("depmax_ovf",2'd0, 32'hFFFF_FFFF,  2'd1, 32'd99_999_999, 4);

        // Test 5: clear, reserved op, clear ignoring amount
        do_txn("clr0",      2'd2, 32'd77,  2'd0, 32'd0,   5);
        do_txn("dep500",    2'd0, 32'd500, 2'd0, 32'd500, 6);
        do_txn("op3",       2'd3, 32'd5,   2'd3, 32'd500, 6);
        do_txn("clr77",     2'd2, 32'd77,  2'd0, 32'd0,   7);
        do_txn("wd0",       2'd1, 32'd0,   2'd0, 32'd0,   8);

        // Test 4: back-pressure with a failing transaction (status nonzero)
        send("bp", 2'd1, 32'd100);
        tick();                       // now in RESP
        txn_valid  = 1'b1;            // next request waits
        txn_op     = 2'd0;
        txn_amount = 32'd20;
        for (int i = 0; i < 10; i++) begin
            check("bp_ready_low", {31'd0, txn_ready},   32'd0);
            check("bp_rvalid",    {31'd0, resp_valid},  32'd1);
            check("bp_status",    {30'd0, resp_status}, 32'd2);
            tick();
        end
        check("bp_balance", balance, 32'd0);
        resp_ready = 1'b1;
        tick();                       // edge M: one handshake
        resp_ready = 1'b0;
        check("bp_ready_back",  {31'd0, txn_ready},  32'd1);
        check("bp_rvalid_drop", {31'd0, resp_valid}, 32'd0);
        $display("txn bp: back-pressured response taken");
        tick();                       // edge M+1: waiting request accepted
        txn_valid = 1'b0;
        check("bp_next_accept", {31'd0, txn_ready},  32'd0);
        check("bp_no_resp",     {31'd0, resp_valid}, 32'd0);
        finish("bp_dep20", 2'd0, 32'd20, 9);

        // Test 6: asynchronous reset while in EXEC
        send("rst_mid", 2'd0, 32'd5);
        #2;
        rst_neg = 1'b0;
        #1;
        check("amid_balance", balance, 32'd0);
        check("amid_ready",   {31'd0, txn_ready},  32'd1);
        check("amid_rvalid",  {31'd0, resp_valid}, 32'd0);
        check("amid_count",   {16'd0, txn_count},  32'd0);
        tick();
        tick();
        check("amid_no_resp", {31'd0, resp_valid}, 32'd0);
        rst_neg = 1'b1;
        tick();
        $display("txn rst_mid: abandoned by reset");
        do_txn("post_rst", 2'd0, 32'd7, 2'd0, 32'd7, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
